// File: rtl/input_sequencer_if.sv
// Host/core-facing bundle for input_sequencer: host symbol handshake, core step acknowledge,
// and the issue strobe, data and sequence flags that go to the embedding stage.
interface input_sequencer_if #(
  parameter int unsigned RAW_INPUT_BIT = 1,
  parameter int unsigned FIFO_DEPTH    = 8
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [RAW_INPUT_BIT-1:0] in_data;
  logic                     step_done;
  logic                     seq_abort;
  logic [RAW_INPUT_BIT-1:0] rawSample_out;
  logic                     newSample_out;
  logic                     seq_start;
  logic                     seq_end;
  logic                     seq_done;
  logic                     busy;
  logic [CntW-1:0]          fifo_count;
  logic                     timeout_err;

  modport master (
    output in_valid, in_data, step_done, seq_abort,
    input  in_ready, rawSample_out, newSample_out, seq_start, seq_end, seq_done, busy,
           fifo_count, timeout_err
  );

  modport slave (
    input  in_valid, in_data, step_done, seq_abort,
    output in_ready, rawSample_out, newSample_out, seq_start, seq_end, seq_done, busy,
           fifo_count, timeout_err
  );
endinterface

// File: rtl/input_sequencer.sv
// Buffers host symbols in a FIFO and issues them one per LSTM timestep with sequence flags.
// Define SEQ_TIMEOUT_EN to add a watchdog that self-acknowledges a stalled timestep.
module input_sequencer #(
  parameter int unsigned RAW_INPUT_BIT  = 1,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SEQ_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              clock,
  input logic              reset,
  input_sequencer_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned StepW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                   stateQ, stateD;
  logic [RAW_INPUT_BIT-1:0] fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0]          wrPtrQ, rdPtrQ;
  logic [CntW-1:0]          countQ;
  logic [StepW-1:0]         stepCntQ;
  logic [RAW_INPUT_BIT-1:0] dataQ;
  logic                     newQ, startQ, endQ, doneQ;
  logic                     inReady, push, pop, ack, lastStep, timeoutHit, timeoutErr;

  assign inReady  = (countQ != CntW'(FIFO_DEPTH));
  assign push     = bus.in_valid && inReady && !bus.seq_abort;
  assign lastStep = (stepCntQ == StepW'(SEQ_LEN - 1));
  assign ack      = (stateQ == StWait) && (bus.step_done || timeoutHit);

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wdCntQ;
  logic           timeoutErrQ;

  assign timeoutHit = (stateQ == StWait) && (wdCntQ == WdW'(TIMEOUT_CYCLES - 1));
  assign timeoutErr = timeoutErrQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdCntQ      <= '0;
      timeoutErrQ <= 1'b0;
    end else begin
      if (stateQ != StWait || pop || bus.step_done || bus.seq_abort || timeoutHit) begin
        wdCntQ <= '0;
      end else begin
        wdCntQ <= wdCntQ + 1'b1;
      end
      if (timeoutHit) timeoutErrQ <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stateQ <= StIdle;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    pop    = 1'b0;
    if (bus.seq_abort) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (countQ != '0) begin
            pop    = 1'b1;
            stateD = StWait;
          end
        end
        StWait: begin
          if (ack) begin
            if (countQ != '0) pop = 1'b1;
            else              stateD = StIdle;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.in_ready      = inReady;
    bus.rawSample_out = dataQ;
    bus.newSample_out = newQ;
    bus.seq_start     = startQ;
    bus.seq_end       = endQ;
    bus.seq_done      = doneQ;
    bus.busy          = (stateQ == StWait);
    bus.fifo_count    = countQ;
    bus.timeout_err   = timeoutErr;
  end

  // Storage is not reset; reset and abort discard contents through the pointers.
  always_ff @(posedge clock) begin
    if (push) fifoMem[wrPtrQ] <= bus.in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else if (bus.seq_abort) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      countQ <= countQ + CntW'(push) - CntW'(pop);
    end
  end

  // endQ still describes the outstanding step when its acknowledge arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataQ    <= '0;
      newQ     <= 1'b0;
      startQ   <= 1'b0;
      endQ     <= 1'b0;
      doneQ    <= 1'b0;
      stepCntQ <= '0;
    end else begin
      newQ  <= pop;
      doneQ <= !bus.seq_abort && (stateQ == StWait) && bus.step_done && endQ;
      if (bus.seq_abort) begin
        stepCntQ <= '0;
      end else if (pop) begin
        dataQ    <= fifoMem[rdPtrQ];
        startQ   <= (stepCntQ == '0);
        endQ     <= lastStep;
        stepCntQ <= lastStep ? '0 : stepCntQ + 1'b1;
      end
    end
  end
endmodule

// File: doc/input_sequencer.md
# input_sequencer

Upstream feeder for the embedding stage. Accepts raw input symbols from the host over a valid/ready handshake, buffers them in a small FIFO, and issues one symbol at a time to the embedding lookup as a held data word plus a one-cycle `newSample_out` pulse. It issues the next symbol only after the LSTM core acknowledges the current timestep. It also tracks timestep position within a fixed-length sequence so the core can reset hidden state at sequence start.

## Interface
- `RAW_INPUT_BIT`, 1: width of one raw symbol.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `SEQ_LEN`, 16: timesteps per sequence; ≥1.
- `TIMEOUT_CYCLES`, 1024: watchdog limit; used only with `SEQ_TIMEOUT_EN`.
- `clock` input, 1: single clock, rising edge.
- `reset` input, 1: asynchronous, active-low.
- `in_valid` input, 1: host symbol valid.
- `in_ready` output, 1: FIFO can accept a symbol.
- `in_data` input, `RAW_INPUT_BIT`: host symbol.
- `step_done` input, 1: core finished the current timestep (pulse).
- `seq_abort` input, 1: synchronous flush of the FIFO and position.
- `rawSample_out` output, `RAW_INPUT_BIT`: symbol to the embedding stage.
- `newSample_out` output, 1: one-cycle issue strobe.
- `seq_start` output, 1: issued symbol is step 0; valid with `newSample_out`.
- `seq_end` output, 1: issued symbol is step `SEQ_LEN-1`; valid with `newSample_out`.
- `seq_done` output, 1: one-cycle pulse when the last step is acknowledged.
- `busy` output, 1: FSM in WAIT.
- `fifo_count` output, `log2(FIFO_DEPTH)+1`: current occupancy.
- `timeout_err` output, 1: sticky watchdog flag.

## Operation
- **FIFO**
  - `in_ready = (fifo_count != FIFO_DEPTH)`. It is combinational from the count and does not depend on a same-cycle pop.
  - Push occurs on `in_valid && in_ready`.
  - A pop occurs only on issue.
  - Simultaneous push and pop leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states: IDLE, WAIT.**
  - IDLE, `fifo_count>0`: pop, load `rawSample_out`, pulse `newSample_out`, go to WAIT.
  - IDLE, FIFO empty: stay in IDLE.
  - WAIT, `step_done=0`: stay in WAIT.
  - WAIT, `step_done=1`, FIFO non-empty: pop, issue the next symbol back-to-back, stay in WAIT.
  - WAIT, `step_done=1`, FIFO empty: go to IDLE.
  - `step_done` is accepted in any WAIT cycle, including the strobe cycle.
  - `step_done` in IDLE is ignored.
- **Step counter `step_cnt`** (0..`SEQ_LEN-1`)
  - Increments on each issue and wraps to 0 after `SEQ_LEN-1`.
  - `seq_start` is asserted when the issued step is 0; `seq_end` when it is `SEQ_LEN-1`.
  - With `SEQ_LEN=1`, both are asserted on every issue.
  - `seq_done` pulses the cycle after a `step_done` is accepted for a step flagged `seq_end`.
- **Data hold:** `rawSample_out` holds its value until the next issue. The embedding stage samples it on the falling edge while `newSample_out` is high.
- **`seq_abort`** (synchronous, highest priority)
  - Empties the FIFO, zeroes `step_cnt`, and sends the FSM to IDLE.
  - Suppresses any issue and any push in that cycle.
  - Does not clear `timeout_err`.

## Timing
- **Reset values:** `in_ready=1`, `rawSample_out=0`, `newSample_out=0`, `seq_start=0`, `seq_end=0`, `seq_done=0`, `busy=0`, `fifo_count=0`, `timeout_err=0`; FSM in IDLE; `step_cnt=0`.
- **Latency:** a symbol accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. `newSample_out` is then high for the cycle between edges N+1 and N+2.
- **Back-to-back issue:** `step_done` high at edge M with the FIFO non-empty gives `newSample_out` high in cycle M..M+1. The minimum spacing between strobes is 1 cycle.
- **Flag timing:** `seq_start`, `seq_end` and `busy` are registered and change on the issue edge.
- **Reset mid-operation:** asserting `reset` at any time immediately forces the reset values and discards buffered symbols.

## Configuration
- **`SEQ_TIMEOUT_EN` defined**
  - A watchdog counter runs in WAIT and clears on every issue or `step_done`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM behaves as if `step_done` had arrived.
  - `timeout_err` is set and stays set until `reset`.
  - No `seq_done` pulse is generated on a timed-out last step.
- **`SEQ_TIMEOUT_EN` undefined:** no watchdog logic; `timeout_err` is tied to 0; the FSM waits in WAIT indefinitely.

## Test plan
- **Single symbol:** push `in_data=1` at edge 5 with the FSM in IDLE. Expect `newSample_out=1`, `rawSample_out=1`, `seq_start=1` in cycle 6 only, then `busy=1` until `step_done`, then IDLE with `busy=0`.
- **Fill and back-pressure:** `FIFO_DEPTH=8`, never send `step_done`, push 10 symbols. Expect 1 issued, 8 buffered, `in_ready=0`, the 10th symbol held off until the first `step_done`, and no data lost or reordered.
- **Back-to-back issue:** keep 4 symbols buffered, pulse `step_done` every cycle. Expect 4 consecutive `newSample_out` pulses in FIFO order.
- **Sequence wrap:** `SEQ_LEN=3`, 7 symbols. Expect `seq_start` on issues 1, 4, 7, `seq_end` on issues 3 and 6, and `seq_done` after acknowledgement of issues 3 and 6.
- **Abort and async reset:** assert `seq_abort` with 5 symbols buffered. Expect `fifo_count=0` next cycle, IDLE, and the next issued symbol flagged `seq_start`. Drop `reset` mid-WAIT: all outputs return to reset values immediately.
- **Watchdog** (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`): with no `step_done`, expect `timeout_err=1` and the next buffered symbol issued 16 cycles after the previous issue. With the macro undefined, the FSM holds WAIT for 1000 cycles with `timeout_err=0`.
